// File: rtl/pc_pkg.sv
// Shared constants and types for the program-counter / call-stack unit.
package pc_pkg;

   localparam int PC_W_DEF = 10;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FAULT = 1'b1
   } pc_state_t;

   localparam logic [1:0] FC_NONE = 2'b00;
   localparam logic [1:0] FC_OVF  = 2'b01;
   localparam logic [1:0] FC_UNF  = 2'b10;

   // Opcodes shared with the decoder so BSR/RET detection and PC control agree.
   localparam logic [11:0] OPC_BSR = 12'b011100000000;
   localparam logic [11:0] OPC_RET = 12'b000000000011;

endpackage

// File: rtl/return_stack.sv
// Return-address register stack; depth doubles as the push/pop pointer.
// Callers must never push when full or pop when empty.
module return_stack #(
   parameter int PC_W  = 10,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [PC_W-1:0]          data_i,
   output logic [PC_W-1:0]          top_o,
   output logic [$clog2(DEPTH):0]   depth_o,
   output logic                     full_o,
   output logic                     empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int DW = AW + 1;
   localparam logic [DW-1:0] D_ONE  = {{(DW-1){1'b0}}, 1'b1};
   localparam logic [DW-1:0] D_ZERO = {DW{1'b0}};
   localparam logic [DW-1:0] D_MAX  = DW'(DEPTH);

   logic [PC_W-1:0] stack_q [DEPTH];
   logic [DW-1:0]   depth_q;
   logic [DW-1:0]   depth_d;
   logic [DW-1:0]   top_idx_s;

   // Depth pointer next-state.
   always_comb begin
      depth_d = depth_q;
      if (push_i) begin
         depth_d = depth_q + D_ONE;
      end else if (pop_i) begin
         depth_d = depth_q - D_ONE;
      end else begin
         depth_d = depth_q;
      end
   end

   // Depth pointer register.
   always_ff @(posedge clk) begin
      if (reset) begin
         depth_q <= D_ZERO;
      end else begin
         depth_q <= depth_d;
      end
   end

   // Stack storage; contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      if (push_i && !reset) begin
         stack_q[depth_q[AW-1:0]] <= data_i;
      end
   end

   // Read port and status flags.
   always_comb begin
      top_idx_s = depth_q - D_ONE;
      top_o     = stack_q[top_idx_s[AW-1:0]];
      depth_o   = depth_q;
      full_o    = (depth_q == D_MAX);
      empty_o   = (depth_q == D_ZERO);
   end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with hardware BSR/RET return stack and a sticky
// overflow/underflow fault state left only through reset.
module pc_call_stack
   import pc_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter int              DEPTH    = 8,
   parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   hold,
   input  logic                   bsr_det,
   input  logic                   ret_det,
   input  logic [PC_W-1:0]        relative_jump,
   output logic [PC_W-1:0]        pc,
   output logic [$clog2(DEPTH):0] depth,
   output logic                   stack_full,
   output logic                   fault,
   output logic [1:0]             fault_code
);
   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   pc_state_t       state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [1:0]      fc_q, fc_d;
   logic            push_s, pop_s;
   logic [PC_W-1:0] top_s;
   logic            full_s, empty_s;

   return_stack #(.PC_W(PC_W), .DEPTH(DEPTH)) u_stack (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .data_i  (pc_q + PC_ONE),
      .top_o   (top_s),
      .depth_o (depth),
      .full_o  (full_s),
      .empty_o (empty_s)
   );

   // State, PC and fault-code registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_PC;
         fc_q    <= FC_NONE;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         fc_q    <= fc_d;
      end
   end

   // Next-state: BSR beats RET; relative_jump is already PC_W wide so the add wraps.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      fc_d    = fc_q;
      push_s  = 1'b0;
      pop_s   = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (hold) begin
               pc_d = pc_q;
            end else if (bsr_det) begin
               if (full_s) begin
                  state_d = ST_FAULT;
                  fc_d    = FC_OVF;
               end else begin
                  push_s = 1'b1;
                  pc_d   = pc_q + relative_jump;
               end
            end else if (ret_det) begin
               if (empty_s) begin
                  state_d = ST_FAULT;
                  fc_d    = FC_UNF;
               end else begin
                  pop_s = 1'b1;
                  pc_d  = top_s;
               end
            end else begin
               pc_d = pc_q + PC_ONE;
            end
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_FAULT;
         end
      endcase
   end

   // Output decode of registered state.
   always_comb begin
      pc         = pc_q;
      stack_full = full_s;
      fault      = (state_q == ST_FAULT);
      fault_code = fc_q;
   end

endmodule

// File: tb/tb_pc_call_stack.sv
// Scoreboard bench for pc_call_stack: a behavioural model queues the expected
// outputs for every driven cycle and they are compared after the clock edge.
module tb_pc_call_stack;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       hold = 1'b0;
   logic       bsr_det = 1'b0;
   logic       ret_det = 1'b0;
   logic [9:0] relative_jump = 10'h000;
   logic [9:0] pc;
   logic [3:0] depth;
   logic       stack_full;
   logic       fault;
   logic [1:0] fault_code;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [9:0] pc;
      logic [3:0] depth;
      logic       full;
      logic       fault;
      logic [1:0] fc;
   } exp_t;

   exp_t sb_q[$];

   logic [9:0] m_pc = 10'h000;
   int         m_depth = 0;
   logic [9:0] m_stk[8];
   logic       m_fault = 1'b0;
   logic [1:0] m_fc = 2'b00;

   pc_call_stack dut (
      .clk           (clk),
      .reset         (reset),
      .hold          (hold),
      .bsr_det       (bsr_det),
      .ret_det       (ret_det),
      .relative_jump (relative_jump),
      .pc            (pc),
      .depth         (depth),
      .stack_full    (stack_full),
      .fault         (fault),
      .fault_code    (fault_code)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic h, input logic b, input logic rt,
                       input logic [9:0] rj);
      exp_t e;
      @(negedge clk);
      reset = r; hold = h; bsr_det = b; ret_det = rt; relative_jump = rj;
      if (r) begin
         m_pc = 10'h000; m_depth = 0; m_fault = 1'b0; m_fc = 2'b00;
      end else if (!h && !m_fault) begin
         if (b) begin
            if (m_depth < 8) begin
               m_stk[m_depth] = m_pc + 10'h001;
               m_depth++;
               m_pc = m_pc + rj;
            end else begin
               m_fault = 1'b1; m_fc = 2'b01;
            end
         end else if (rt) begin
            if (m_depth > 0) begin
               m_depth--;
               m_pc = m_stk[m_depth];
            end else begin
               m_fault = 1'b1; m_fc = 2'b10;
            end
         end else begin
            m_pc = m_pc + 10'h001;
         end
      end
      e.pc = m_pc; e.depth = 4'(m_depth); e.full = (m_depth == 8);
      e.fault = m_fault; e.fc = m_fc;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check("pc", 32'(pc), 32'(e.pc));
      check("depth", 32'(depth), 32'(e.depth));
      check("stack_full", 32'(stack_full), 32'(e.full));
      check("fault", 32'(fault), 32'(e.fault));
      check("fault_code", 32'(fault_code), 32'(e.fc));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
   endtask

   task automatic bsr(input logic [9:0] rj);
      step(1'b0, 1'b0, 1'b1, 1'b0, rj);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
   endtask

   initial begin
      // Reset and free-run
      do_reset();
      check("reset_pc", 32'(pc), 32'h000);
      idle(4);
      check("free_run_pc", 32'(pc), 32'h004);
      bsr(10'h010);
      check("bsr_target", 32'(pc), 32'h014);
      idle(3);
      check("after_idle", 32'(pc), 32'h017);
      step(1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
      check("ret_addr", 32'(pc), 32'h005);
      check("ret_depth", 32'(depth), 32'h0);

      // Negative offset and wrap
      do_reset();
      idle(3);
      bsr(10'h3FE);
      check("neg_offset", 32'(pc), 32'h001);
      do_reset();
      bsr(10'h3FF);
      check("pc_max", 32'(pc), 32'h3FF);
      idle(1);
      check("pc_wrap", 32'(pc), 32'h000);

      // Overflow
      do_reset();
      for (int i = 0; i < 8; i++) bsr(10'h001);
      check("full_depth", 32'(depth), 32'h8);
      check("full_flag", 32'(stack_full), 32'h1);
      bsr(10'h001);
      check("ovf_code", 32'(fault_code), 32'h1);
      idle(4);
      check("ovf_frozen", 32'(pc), 32'h008);
      do_reset();
      check("ovf_cleared", 32'(fault), 32'h0);

      // Underflow
      idle(7);
      step(1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
      check("unf_code", 32'(fault_code), 32'h2);
      check("unf_pc", 32'(pc), 32'h007);

      // Hold with BSR pending
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 10'h020);
      check("hold_pc", 32'(pc), 32'h000);
      bsr(10'h020);
      idle(1);
      check("hold_release", 32'(pc), 32'h021);

      // Reset with BSR: no push, so a RET underflows
      step(1'b1, 1'b0, 1'b1, 1'b0, 10'h020);
      check("rst_bsr_depth", 32'(depth), 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
      check("rst_bsr_unf", 32'(fault), 32'h1);

      // BSR and RET together
      do_reset();
      bsr(10'h004);
      bsr(10'h004);
      step(1'b0, 1'b0, 1'b1, 1'b1, 10'h004);
      check("both_depth", 32'(depth), 32'h3);

      // Random traffic
      do_reset();
      for (int i = 0; i < 400; i++) begin
         logic r, h, b, rt;
         logic [9:0] rj;
         r  = ($urandom_range(0, 39) == 0);
         h  = ($urandom_range(0, 4) == 0);
         b  = ($urandom_range(0, 3) == 0);
         rt = ($urandom_range(0, 3) == 0);
         rj = 10'($urandom_range(0, 1023));
         step(r, h, b, rt, rj);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
